pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed-width, always-enabled inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload and a generic control bundle between two pipeline stages.
- Adds a valid/ready handshake, an optional two-entry skid buffer, synchronous flush, and bubble insertion (control forced to zero when the stage holds no valid entry).
- Instantiated once per stage boundary in the CPU top level.

Parameters:
- DATA_W, 160, payload width in bits (e.g. inst, pc, two read-data words and the sign-extended immediate = 5x32); legal range 1..512.
- CTRL_W, 8, control bundle width in bits (RegDst, ALUOp, ALUSrc, RegWrite, MemToReg, MemWrite, ...); legal range 1..64.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- BUBBLE_ZERO, 1, 1 = out_ctrl_o forced to 0 whenever out_valid_o = 0; 0 = out_ctrl_o always shows the main register.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- flush_i  input  1  synchronous flush: discards all held entries.
- in_valid_i  input  1  upstream stage presents a valid entry.
- in_ready_o  output  1  this stage accepts an entry this cycle.
- in_data_i  input  DATA_W  upstream payload.
- in_ctrl_i  input  CTRL_W  upstream control bundle.
- out_valid_o  output  1  an entry is presented downstream.
- out_ready_i  input  1  downstream stage accepts the entry.
- out_data_o  output  DATA_W  payload from the main register.
- out_ctrl_o  output  CTRL_W  control from the main register, subject to BUBBLE_ZERO.
- occupancy_o  output  2  number of held entries: 0..2 when SKID=1, 0..1 when SKID=0.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state EMPTY; main and skid data/ctrl registers = 0; out_valid_o = 0; out_data_o = 0; out_ctrl_o = 0; occupancy_o = 0; in_ready_o = 1.
- Handshake:
  - Accept = in_valid_i & in_ready_o.
  - Pop = out_valid_o & out_ready_i.
  - Payload and control are captured only on accept.
  - out_data_o is not cleared on pop; it holds its last value.
- Latency and throughput: 1 cycle from accept to out_valid_o; sustained throughput of 1 entry per cycle when out_ready_i = 1.
- State machine, SKID=1 (states EMPTY / HALF / FULL):
  - in_ready_o = (state != FULL), registered (no combinational path from out_ready_i).
  - EMPTY: accept -> HALF, main <= in.
  - HALF, accept & pop -> HALF, main <= in.
  - HALF, accept only -> FULL, skid <= in.
  - HALF, pop only -> EMPTY.
  - FULL: pop -> HALF, main <= skid. No accept is possible in FULL.
  - Ordering is strictly FIFO.
- State machine, SKID=0 (states EMPTY / HALF only):
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Accept & pop in the same cycle -> HALF with new data.
  - The skid register is not generated.
- Flush:
  - flush_i = 1 -> next state EMPTY; out_valid_o = 0 and occupancy_o = 0 on the next cycle.
  - Flush has priority over a simultaneous accept and a simultaneous pop; the incoming entry is dropped.
  - Data registers keep their values; only valid state is cleared.
- Reset vs flush: rst_i has priority over flush_i. Reset asserted mid-transfer discards all entries on the next edge, identically to flush, and additionally zeroes the data registers.
- occupancy_o: EMPTY = 0, HALF = 1, FULL = 2.
- Bubble: with BUBBLE_ZERO=1, out_ctrl_o = 0 whenever out_valid_o = 0, so a bubble can never write the register file or memory.
- Protocol checks (simulation-only assertions):
  - in_data_i and in_ctrl_i stable while in_valid_i & ~in_ready_o.
  - out_valid_o never drops without a pop or flush.

Test Plan:
- Reset: hold rst_i 2 cycles with in_valid_i = 1 -> out_valid_o = 0, out_ctrl_o = 0, out_data_o = 0, occupancy_o = 0, in_ready_o = 1 on the first cycle after release.
- Streaming (SKID=1, out_ready_i = 1): push 0x11, 0x22, 0x33 on consecutive cycles -> identical values at out_data_o one cycle later, back-to-back; occupancy_o stays 1; in_ready_o never drops.
- Backpressure (out_ready_i = 0): push A = 0xA5, B = 0x5A -> occupancy_o = 2 and in_ready_o = 0; raise out_ready_i -> A, then B on consecutive cycles, then out_valid_o = 0 and in_ready_o = 1.
- Flush while FULL with in_valid_i = 1, in_ctrl_i = 0xFF -> next cycle out_valid_o = 0, out_ctrl_o = 0x00, occupancy_o = 0; the dropped entry never appears at the output.
- SKID=0, out_valid_o = 1: out_ready_i = 0 -> in_ready_o = 0 in the same cycle; out_ready_i = 1 with a push of 0x44 -> out_data_o = 0x44 next cycle with no bubble.
- Reset mid-operation while FULL with out_ready_i = 1 -> next cycle EMPTY, no entry popped after the reset edge, data registers = 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready
// handshake, optional two-entry skid buffer, synchronous flush and bubble
// zeroing of the control bundle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      synchronous flush, discards all held entries
//   in_valid_i   upstream entry valid
//   in_ready_o   stage accepts an entry this cycle
//   in_data_i    upstream payload   [DATA_W]
//   in_ctrl_i    upstream control   [CTRL_W]
//   out_valid_o  entry presented downstream
//   out_ready_i  downstream accepts the entry
//   out_data_o   payload from the main register
//   out_ctrl_o   control from the main register (zeroed on bubbles if BUBBLE_ZERO)
//   occupancy_o  number of held entries (0..2)
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 160,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned SKID        = 1,
  parameter int unsigned BUBBLE_ZERO = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT             stateQ;
  stateT             stateNext;
  logic [DATA_W-1:0] mainDataQ;
  logic [CTRL_W-1:0] mainCtrlQ;
  logic [DATA_W-1:0] skidDataQ;
  logic [CTRL_W-1:0] skidCtrlQ;
  logic              outValid;
  logic              accept;
  logic              pop;
  logic              loadMainIn;
  logic              loadMainSkid;
  logic              loadSkid;

  assign outValid = (stateQ != EMPTY);
  assign accept   = in_valid_i & in_ready_o;
  assign pop      = outValid & out_ready_i;

  // Next-state and register load selection; flush overrides any transfer.
  always_comb begin
    stateNext    = stateQ;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush_i) begin
      stateNext = EMPTY;
    end else begin
      case (stateQ)
        EMPTY: begin
          if (accept) begin
            stateNext  = HALF;
            loadMainIn = 1'b1;
          end
        end
        HALF: begin
          if (accept && pop) begin
            loadMainIn = 1'b1;
          end else if (accept) begin
            // Without a skid entry, ready implies pop, so this only fires with SKID.
            if (SKID != 0) begin
              stateNext = FULL;
              loadSkid  = 1'b1;
            end else begin
              loadMainIn = 1'b1;
            end
          end else if (pop) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            stateNext    = HALF;
            loadMainSkid = 1'b1;
          end
        end
        default: begin
          stateNext = EMPTY;
        end
      endcase
    end
  end

  // State and main entry register; flush leaves the data untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateQ    <= EMPTY;
      mainDataQ <= '0;
      mainCtrlQ <= '0;
    end else begin
      stateQ <= stateNext;
      if (loadMainIn) begin
        mainDataQ <= in_data_i;
        mainCtrlQ <= in_ctrl_i;
      end else if (loadMainSkid) begin
        mainDataQ <= skidDataQ;
        mainCtrlQ <= skidCtrlQ;
      end
    end
  end

  generate
    if (SKID != 0) begin : gSkid
      logic inReadyQ;

      // Skid entry plus registered ready, so out_ready_i never reaches in_ready_o.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          skidDataQ <= '0;
          skidCtrlQ <= '0;
          inReadyQ  <= 1'b1;
        end else begin
          if (loadSkid) begin
            skidDataQ <= in_data_i;
            skidCtrlQ <= in_ctrl_i;
          end
          inReadyQ <= (stateNext != FULL);
        end
      end

      assign in_ready_o = inReadyQ;
    end else begin : gNoSkid
      assign skidDataQ  = '0;
      assign skidCtrlQ  = '0;
      assign in_ready_o = ~outValid | out_ready_i;
    end
  endgenerate

  // Occupancy decode of the state register.
  always_comb begin
    occupancy_o = 2'd0;
    case (stateQ)
      HALF:    occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign out_valid_o = outValid;
  assign out_data_o  = mainDataQ;

  // Bubbles carry zero control so they can never write state downstream.
  generate
    if (BUBBLE_ZERO != 0) begin : gBubbleZero
      assign out_ctrl_o = outValid ? mainCtrlQ : '0;
    end else begin : gBubbleKeep
      assign out_ctrl_o = mainCtrlQ;
    end
  endgenerate

  // Upstream must hold its payload while stalled.
  aInStable : assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i && !in_ready_o && !flush_i) |=>
      (!in_valid_i || ($stable(in_data_i) && $stable(in_ctrl_i))));

  // A presented entry only leaves through a pop or a flush.
  aOutHold : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=> out_valid_o);

endmodule
